// File: rtl/irq_source_ctrl_pkg.sv
// Shared register offsets, interrupt-bus width and slave register select type.
// Imported by the controller top and the testbench.
package irq_source_ctrl_pkg;

    localparam int INT_BUS_W  = 8;
    localparam int CLAIM_ID_W = $clog2(INT_BUS_W + 1);

    localparam logic [7:0] IRQ_PENDING = 8'h00;
    localparam logic [7:0] IRQ_ENABLE  = 8'h04;
    localparam logic [7:0] IRQ_TRIGGER = 8'h08;
    localparam logic [7:0] IRQ_CLAIM   = 8'h0C;
    localparam logic [7:0] IRQ_SWSET   = 8'h10;

    typedef enum logic [2:0] {
        REG_PENDING,
        REG_ENABLE,
        REG_TRIGGER,
        REG_CLAIM,
        REG_SWSET,
        REG_NONE
    } reg_sel_e;

endpackage

// File: rtl/irq_source_ctrl_if.sv
// Memory-mapped slave port of the interrupt source controller.
// One-cycle request strobe, acknowledged on the following edge; no backpressure.
interface irq_source_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [DATA_W-1:0] rdata_o;
    logic              ack_o;

    modport master (output req_i, we_i, addr_i, wdata_i, input rdata_o, ack_o);
    modport slave  (input req_i, we_i, addr_i, wdata_i, output rdata_o, ack_o);
endinterface

// File: rtl/irq_source_ctrl_gateway.sv
// One interrupt source: synchroniser, edge/level gateway, pending and in-service flops.
// Pending sets SYNC_STAGES edges after the line rises; never stalls.
module irq_gateway #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_irq,
    input  logic i_edge_mode,
    input  logic i_sw_set,
    input  logic i_claim,
    input  logic i_complete,
    output logic o_pending,
    output logic o_in_service
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_pending;
    logic                   r_in_service;
    logic                   w_s;
    logic                   w_set;

    assign w_s = r_sync[SYNC_STAGES-1];

    // A level source is not re-armed by the claim that is consuming it;
    // it returns on the edge after complete if the line is still high.
    assign w_set = i_sw_set
                 | (i_edge_mode ? (w_s & ~r_prev)
                                : (w_s & ~r_in_service & ~i_claim));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync       <= '0;
            r_prev       <= 1'b0;
            r_pending    <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            r_sync       <= {r_sync[SYNC_STAGES-2:0], i_irq};
            r_prev       <= w_s;
            r_pending    <= w_set | (r_pending & ~i_claim);
            r_in_service <= i_claim | (r_in_service & ~i_complete);
        end
    end

    assign o_pending    = r_pending;
    assign o_in_service = r_in_service;

endmodule

// File: rtl/irq_source_ctrl.sv
// Interrupt source controller: per-source gateways, fixed priority select, claim/complete slave.
// int_flag_o is combinational from state flops; slave acks every request one cycle later.
module irq_source_ctrl
    import irq_source_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = INT_BUS_W,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src_i,
    irq_source_ctrl_if.slave   bus,
    output logic [NUM_SRC-1:0] int_flag_o
);

    localparam int ID_W = $clog2(NUM_SRC + 1);

    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_trigger;
    logic               r_ack;
    logic [DATA_W-1:0]  r_rdata;

    logic [NUM_SRC-1:0] w_pending;
    logic [NUM_SRC-1:0] w_in_service;
    logic [NUM_SRC-1:0] w_cand;
    logic [NUM_SRC-1:0] w_onehot;
    logic [ID_W-1:0]    w_id;
    logic [NUM_SRC-1:0] w_claim_vec;
    logic [NUM_SRC-1:0] w_complete_vec;
    logic [NUM_SRC-1:0] w_swset_vec;
    logic [ADDR_W-1:0]  w_word;
    reg_sel_e           w_sel;
    logic               w_rd;
    logic               w_wr;
    logic [DATA_W-1:0]  w_rd_dat;
    logic               w_unused_addr;

    assign w_rd          = bus.req_i & ~bus.we_i;
    assign w_wr          = bus.req_i &  bus.we_i;
    assign w_word        = {bus.addr_i[ADDR_W-1:2], 2'b00};
    assign w_unused_addr = ^bus.addr_i[1:0];

    always_comb begin
        w_sel = REG_NONE;
        case (w_word)
            ADDR_W'(IRQ_PENDING): w_sel = REG_PENDING;
            ADDR_W'(IRQ_ENABLE):  w_sel = REG_ENABLE;
            ADDR_W'(IRQ_TRIGGER): w_sel = REG_TRIGGER;
            ADDR_W'(IRQ_CLAIM):   w_sel = REG_CLAIM;
            ADDR_W'(IRQ_SWSET):   w_sel = REG_SWSET;
            default:              w_sel = REG_NONE;
        endcase
    end

    // Index 0 wins: scan from the top so the lowest set bit is written last.
    assign w_cand = w_pending & r_enable & ~w_in_service;

    always_comb begin
        w_onehot = '0;
        w_id     = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
                w_id        = ID_W'(i + 1);
            end
        end
    end

    assign int_flag_o  = (|w_in_service) ? '0 : w_onehot;
    assign w_claim_vec = (w_rd && w_sel == REG_CLAIM) ? w_onehot : '0;
    assign w_swset_vec = (w_wr && w_sel == REG_SWSET) ? bus.wdata_i[NUM_SRC-1:0] : '0;

    // Completing an id that is not in service clears an already-clear flop.
    always_comb begin
        w_complete_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_complete_vec[i] = w_wr && (w_sel == REG_CLAIM)
                              && (bus.wdata_i == DATA_W'(i + 1));
        end
    end

    always_comb begin
        w_rd_dat = '0;
        case (w_sel)
            REG_PENDING: w_rd_dat[NUM_SRC-1:0] = w_pending;
            REG_ENABLE:  w_rd_dat[NUM_SRC-1:0] = r_enable;
            REG_TRIGGER: w_rd_dat[NUM_SRC-1:0] = r_trigger;
            REG_CLAIM:   w_rd_dat[ID_W-1:0]    = w_id;
            default:     w_rd_dat              = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enable  <= '0;
            r_trigger <= '0;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_ack   <= bus.req_i;
            r_rdata <= w_rd ? w_rd_dat : '0;
            if (w_wr && w_sel == REG_ENABLE) begin
                r_enable <= bus.wdata_i[NUM_SRC-1:0];
            end
            if (w_wr && w_sel == REG_TRIGGER) begin
                r_trigger <= bus.wdata_i[NUM_SRC-1:0];
            end
        end
    end

    assign bus.ack_o   = r_ack;
    assign bus.rdata_o = r_rdata;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        irq_gateway #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_gw (
            .clk          (clk),
            .rst          (rst),
            .i_irq        (irq_src_i[g]),
            .i_edge_mode  (r_trigger[g]),
            .i_sw_set     (w_swset_vec[g]),
            .i_claim      (w_claim_vec[g]),
            .i_complete   (w_complete_vec[g]),
            .o_pending    (w_pending[g]),
            .o_in_service (w_in_service[g])
        );
    end

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed and random checks of irq_source_ctrl against a rule-level reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_irq_source_ctrl;
    import irq_source_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq_src = '0;
    logic [7:0] int_flag;

    irq_source_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    irq_source_ctrl #(
        .NUM_SRC     (8),
        .ADDR_W      (8),
        .DATA_W      (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src_i  (irq_src),
        .bus        (bus),
        .int_flag_o (int_flag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state; smp1/2/3 are the line samples taken 1/2/3 edges ago.
    logic [7:0]  m_pend, m_en, m_trig, m_ins, m_smp1, m_smp2, m_smp3;
    logic        m_ack;
    logic [31:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int prio_id(input logic [7:0] c);
        for (int i = 0; i < 8; i++) if (c[i]) return i + 1;
        return 0;
    endfunction

    function automatic logic [7:0] exp_flag();
        int id;
        id = prio_id(m_pend & m_en & ~m_ins);
        if (m_ins != 8'h00 || id == 0) return 8'h00;
        return 8'(1 << (id - 1));
    endfunction

    task automatic model_reset();
        m_pend = '0; m_en = '0; m_trig = '0; m_ins = '0;
        m_smp1 = '0; m_smp2 = '0; m_smp3 = '0;
        m_ack = 1'b0; m_rdata = '0;
    endtask

    task automatic model_step();
        logic [7:0]  s, prv, cand, claim_v, comp_v, sw, setv, word, new_en, new_trig;
        logic [31:0] wd;
        int          id;
        s = m_smp2; prv = m_smp3;
        word = {bus.addr_i[7:2], 2'b00};
        wd = bus.wdata_i;
        cand = m_pend & m_en & ~m_ins;
        id = prio_id(cand);
        claim_v = '0; comp_v = '0; sw = '0;
        new_en = m_en; new_trig = m_trig;
        m_ack = bus.req_i;
        m_rdata = '0;
        if (bus.req_i && !bus.we_i) begin
            case (word)
                8'h00: m_rdata = {24'h0, m_pend};
                8'h04: m_rdata = {24'h0, m_en};
                8'h08: m_rdata = {24'h0, m_trig};
                8'h0C: begin
                    m_rdata = 32'(id);
                    if (id != 0) claim_v = 8'(1 << (id - 1));
                end
                default: m_rdata = '0;
            endcase
        end
        if (bus.req_i && bus.we_i) begin
            case (word)
                8'h04: new_en = wd[7:0];
                8'h08: new_trig = wd[7:0];
                8'h0C: if (wd >= 1 && wd <= 8) comp_v = 8'(1 << (wd - 1)) & m_ins;
                8'h10: sw = wd[7:0];
                default: ;
            endcase
        end
        setv = (m_trig & s & ~prv) | (~m_trig & s & ~m_ins & ~claim_v) | sw;
        m_pend = setv | (m_pend & ~claim_v);
        m_ins = claim_v | (m_ins & ~comp_v);
        m_en = new_en;
        m_trig = new_trig;
        m_smp3 = m_smp2; m_smp2 = m_smp1; m_smp1 = irq_src;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        @(negedge clk);
        chk("int_flag", {24'h0, int_flag}, {24'h0, exp_flag()});
        chk("ack", {31'h0, bus.ack_o}, {31'h0, m_ack});
        chk("rdata", bus.rdata_o, m_rdata);
    endtask

    task automatic bus_op(input logic we, input logic [7:0] a, input logic [31:0] d);
        bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = a; bus.wdata_i = d;
        cycle();
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
    endtask

    // Reset asserted between edges must clear outputs without waiting for a clock.
    task automatic async_reset_check(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk({tag, "_flag"}, {24'h0, int_flag}, 32'h0);
        chk({tag, "_ack"}, {31'h0, bus.ack_o}, 32'h0);
        chk({tag, "_rdata"}, bus.rdata_o, 32'h0);
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        logic        we;
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
        model_reset();
        cycle();
        cycle();
        chk("reset_flag", {24'h0, int_flag}, 32'h0);
        chk("reset_ack", {31'h0, bus.ack_o}, 32'h0);
        chk("reset_rdata", bus.rdata_o, 32'h0);
        rst = 1'b0;

        // Level source 0: two-edge latency, claim, complete with line high.
        bus_op(1'b1, IRQ_ENABLE, 32'h01);
        irq_src[0] = 1'b1;
        cycle();
        cycle();
        cycle();
        chk("lvl_flag", {24'h0, int_flag}, 32'h01);
        bus_op(1'b0, IRQ_CLAIM, 0);
        chk("lvl_claim_id", bus.rdata_o, 32'd1);
        chk("lvl_claim_flag", {24'h0, int_flag}, 32'h0);
        bus_op(1'b1, IRQ_CLAIM, 1);
        cycle();
        chk("lvl_retrigger", {24'h0, int_flag}, 32'h01);
        bus_op(1'b0, IRQ_CLAIM, 0);
        irq_src[0] = 1'b0;
        repeat (3) cycle();
        bus_op(1'b1, IRQ_CLAIM, 1);

        // Software set, priority order.
        bus_op(1'b1, IRQ_ENABLE, 32'hFF);
        bus_op(1'b1, IRQ_SWSET, 32'h24);
        chk("sw_flag", {24'h0, int_flag}, 32'h04);
        bus_op(1'b0, IRQ_CLAIM, 0);
        chk("sw_claim3", bus.rdata_o, 32'd3);
        bus_op(1'b1, IRQ_CLAIM, 3);
        chk("sw_flag20", {24'h0, int_flag}, 32'h20);
        bus_op(1'b0, IRQ_CLAIM, 0);
        chk("sw_claim6", bus.rdata_o, 32'd6);
        bus_op(1'b1, IRQ_CLAIM, 6);

        // Edge source 1 pulsed while in service: held pending, not presented.
        bus_op(1'b1, IRQ_TRIGGER, 32'h02);
        irq_src[1] = 1'b1; cycle(); irq_src[1] = 1'b0; cycle(); cycle();
        chk("edge_flag", {24'h0, int_flag}, 32'h02);
        bus_op(1'b0, IRQ_CLAIM, 0);
        chk("edge_claim", bus.rdata_o, 32'd2);
        repeat (2) begin
            irq_src[1] = 1'b1; cycle(); irq_src[1] = 1'b0; cycle(); cycle();
        end
        bus_op(1'b0, IRQ_PENDING, 0);
        chk("edge_pend_bit1", {31'h0, bus.rdata_o[1]}, 32'd1);
        chk("edge_held_flag", {24'h0, int_flag}, 32'h0);
        bus_op(1'b1, IRQ_CLAIM, 2);
        chk("edge_after_cmp", {24'h0, int_flag}, 32'h02);
        bus_op(1'b0, IRQ_CLAIM, 0);
        bus_op(1'b1, IRQ_CLAIM, 2);

        // Edge on source 0 landing on the same edge as its claim.
        bus_op(1'b1, IRQ_TRIGGER, 32'h03);
        irq_src[0] = 1'b1; cycle(); irq_src[0] = 1'b0; cycle(); cycle();
        chk("coin_flag", {24'h0, int_flag}, 32'h01);
        irq_src[0] = 1'b1; cycle(); irq_src[0] = 1'b0; cycle();
        bus_op(1'b0, IRQ_CLAIM, 0);
        chk("coin_claim", bus.rdata_o, 32'd1);
        chk("coin_flag0", {24'h0, int_flag}, 32'h0);
        bus_op(1'b0, IRQ_PENDING, 0);
        chk("coin_pend", bus.rdata_o, 32'h01);
        bus_op(1'b1, IRQ_CLAIM, 1);
        chk("coin_after_cmp", {24'h0, int_flag}, 32'h01);
        bus_op(1'b0, IRQ_CLAIM, 0);
        bus_op(1'b1, IRQ_CLAIM, 1);

        // Ignored completes and an unmapped read.
        bus_op(1'b1, IRQ_SWSET, 32'h10);
        bus_op(1'b0, IRQ_CLAIM, 0);
        chk("ign_claim5", bus.rdata_o, 32'd5);
        bus_op(1'b1, IRQ_SWSET, 32'h01);
        bus_op(1'b1, IRQ_CLAIM, 0);
        chk("ign_ack0", {31'h0, bus.ack_o}, 32'd1);
        bus_op(1'b1, IRQ_CLAIM, 9);
        bus_op(1'b1, IRQ_CLAIM, 3);
        bus_op(1'b0, 8'h14, 0);
        chk("unmapped_rd", bus.rdata_o, 32'h0);
        chk("unmapped_ack", {31'h0, bus.ack_o}, 32'd1);
        bus_op(1'b0, IRQ_PENDING, 0);
        chk("ign_pend", bus.rdata_o, 32'h01);
        chk("ign_flag", {24'h0, int_flag}, 32'h0);
        bus_op(1'b1, IRQ_CLAIM, 5);
        chk("ign_after_cmp", {24'h0, int_flag}, 32'h01);
        bus_op(1'b0, IRQ_CLAIM, 0);
        bus_op(1'b1, IRQ_CLAIM, 1);

        // Reset in the middle of service with everything pending.
        bus_op(1'b1, IRQ_SWSET, 32'hFF);
        bus_op(1'b0, IRQ_CLAIM, 0);
        chk("pre_rst_claim", bus.rdata_o, 32'd1);
        bus_op(1'b0, IRQ_CLAIM, 0);
        async_reset_check("mid_rst");
        repeat (5) cycle();
        chk("post_rst_quiet", {24'h0, int_flag}, 32'h0);
        bus_op(1'b1, IRQ_ENABLE, 32'hFF);
        chk("post_rst_en_quiet", {24'h0, int_flag}, 32'h0);
        bus_op(1'b1, IRQ_SWSET, 32'h08);
        chk("post_rst_new", {24'h0, int_flag}, 32'h08);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            irq_src = irq_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            we = 1'($urandom);
            case ($urandom_range(0, 7))
                0:       a = IRQ_PENDING;
                1:       a = IRQ_ENABLE;
                2:       a = IRQ_TRIGGER;
                3, 4:    a = IRQ_CLAIM;
                5:       a = IRQ_SWSET;
                6:       a = 8'h14;
                default: a = 8'($urandom);
            endcase
            a = a | 8'($urandom_range(0, 3));
            if (a[7:2] == 6'h03) d = $urandom_range(0, 9);
            else if (a[7:2] == 6'h04) d = $urandom & $urandom & $urandom;
            else d = $urandom;
            if ($urandom_range(0, 1) == 1) bus_op(we, a, d);
            else cycle();
            if (i == 1000) async_reset_check("rand_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_source_ctrl.md
Name: irq_source_ctrl

Overview:
- Platform-side interrupt source controller. It drives the core's `int_flag_i` bus (the CPU-side interrupt controller is the consumer).
- Collects peripheral interrupt lines and synchronises them. Each source has its own gateway with edge or level mode; the block keeps pending and enable state.
- Presents at most one request, one-hot and highest priority, to the core.
- Software uses claim/complete through a memory-mapped slave port, so each handled interrupt is acknowledged exactly once and cannot retrigger before the core finishes `mret` handling.

Parameters:
- `NUM_SRC`, 8, number of sources; must equal the `` `INT_BUS`` width.
- `ADDR_W`, 8, slave byte-address width.
- `DATA_W`, 32, slave data width.
- `SYNC_STAGES`, 2, synchroniser flops per source (minimum 2).

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-high reset
- `irq_src_i`  in  `NUM_SRC`  raw peripheral interrupt lines, asynchronous
- `req_i`  in  1  slave access request, one-cycle strobe
- `we_i`  in  1  1 = write, 0 = read
- `addr_i`  in  `ADDR_W`  byte address (bits [1:0] ignored)
- `wdata_i`  in  `DATA_W`  write data
- `rdata_o`  out  `DATA_W`  read data, valid with `ack_o`
- `ack_o`  out  1  access done, one cycle after `req_i`
- `int_flag_o`  out  `NUM_SRC`  one-hot interrupt request to core, 0 = none

Behaviour:
- Reset (asynchronous, `rst`=1):
  - Cleared: synchronisers, previous-sample flops, `pending`, `enable`, `trigger`, `in_service`.
  - `int_flag_o`=0, `ack_o`=0, `rdata_o`=0. Takes effect immediately, including mid-access and mid-service.
- Register map (word offsets):
  - 0x00 PENDING: read-only.
  - 0x04 ENABLE: RW.
  - 0x08 TRIGGER: RW; 1 = edge, 0 = level.
  - 0x0C CLAIM: read = claim, write = complete.
  - 0x10 SWSET: write-1-to-set pending.
  - Unmapped: reads return 0, writes ignored. Bits above `NUM_SRC` read 0.
- Synchroniser:
  - `s[i]` = `irq_src_i[i]` after `SYNC_STAGES` edges.
  - Edge detect: `s[i] & ~s_prev[i]`.
- Gateway set condition for `pending[i]`:
  - Edge mode: rising edge of `s[i]`. Accepted even while `in_service[i]`; held, not presented.
  - Level mode: `s[i]`=1 and `in_service[i]`=0.
  - SWSET bit written 1.
- Latency: source high before edge N. With `SYNC_STAGES`=2, `pending` sets at edge N+2. `int_flag_o` follows in the same cycle; it is combinational from flops, with no extra stage.
- `int_flag_o` rule:
  - `cand` = `pending & enable & ~in_service`.
  - Output = one-hot of the lowest-index set bit of `cand` (index 0 highest priority).
  - Forced to 0 while any `in_service` bit is set (core handles one interrupt at a time).
  - Held until claimed; there is no handshake with the core.
- Claim (read 0x0C):
  - `rdata` = `id` = index+1 of the highest-priority `cand` bit, or 0 if `cand`=0.
  - On the same edge, `pending[id-1]` clears and `in_service[id-1]` sets. `cand`=0 → no state change.
- Complete (write 0x0C):
  - `wdata` = k in 1..`NUM_SRC` with `in_service[k-1]`=1 → clear `in_service[k-1]`.
  - Any other value (0, out of range, not in service) is ignored.
- Simultaneous events:
  - Set beats clear on the same bit in the same cycle (edge or SWSET coincident with claim): `pending` stays 1 and `in_service` still sets.
  - Level source still high after complete: `pending` re-sets on the next edge.
- Disabling `enable[i]` masks the output only; `pending` is kept.
- Slave handshake:
  - Exactly one `ack_o` pulse on the edge after each `req_i`. Back-to-back requests are accepted every cycle.
  - `rdata_o` registered with `ack_o`, 0 otherwise; 0 for writes.
- Claim index width: `$clog2(NUM_SRC+1)`, zero-extended to `DATA_W`.

Decomposition:
- Shared defines: register offsets (`IRQ_PENDING`, `IRQ_ENABLE`, `IRQ_TRIGGER`, `IRQ_CLAIM`, `IRQ_SWSET`), the `` `INT_BUS`` width and the claim-id width constant.
- One sub-module, `irq_gateway`: a single source's synchroniser, edge detect, and `pending`/`in_service` flops. The top instantiates `NUM_SRC` copies and adds the priority select and the slave decode.

Test Plan:
- Reset, ENABLE=0x01, TRIGGER=0, raise `irq_src_i[0]` → `int_flag_o`=0x01 two edges later. Read CLAIM → `rdata`=1 and `int_flag_o`=0. Write CLAIM=1 with the line still high → `int_flag_o`=0x01 again next cycle.
- ENABLE=0xFF, SWSET=0x24 → `int_flag_o`=0x04. Claim → 3; complete 3 → `int_flag_o`=0x20. Claim → 6.
- Edge mode on src 1: pulse twice while in service → PENDING bit1=1, `int_flag_o`=0. Complete 2 → `int_flag_o`=0x02.
- Edge on src 0 coincident with its claim → `rdata`=1, PENDING=0x01, `in_service` set, `int_flag_o`=0 until complete.
- Complete with 0, 9, or an id not in service; read 0x14 → state unchanged, `rdata`=0, one `ack_o` each.
- `rst` pulse mid-service with pending 0xFF → all outputs 0 immediately; no request after release until a new source event.
